// File: rtl/priority_code_decoder_if.sv
// Bus bundle between a code source and the priority code decoder: the index-code
// stream in one direction and the rebuilt-mask result handshake in the other.
interface priority_code_decoder_if #(
    parameter int WIDTH = 16
);
    logic [7:0]       code_in;
    logic             code_valid;
    logic             code_ready;
    logic [WIDTH-1:0] mask_out;
    logic [WIDTH-1:0] onehot_top;
    logic [7:0]       top_idx;
    logic [7:0]       pop_count;
    logic             err_illegal;
    logic             err_dup;
    logic             mask_valid;
    logic             mask_ready;

    // Code source / result consumer side.
    modport master (
        output code_in, code_valid, mask_ready,
        input  code_ready, mask_out, onehot_top, top_idx, pop_count,
               err_illegal, err_dup, mask_valid
    );

    // Decoder side.
    modport slave (
        input  code_in, code_valid, mask_ready,
        output code_ready, mask_out, onehot_top, top_idx, pop_count,
               err_illegal, err_dup, mask_valid
    );
endinterface

// File: rtl/priority_code_decoder.sv
// Rebuilds a request mask from a stream of priority-encoder index codes; each
// frame ends with NONE_CODE and its result is held under a valid/ready handshake.
module priority_code_decoder #(
    parameter int         WIDTH     = 16,
    parameter logic [7:0] NONE_CODE = 8'hF0
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_code_decoder_if.slave bus
);

    localparam int         IDX_W   = $clog2(WIDTH);
    localparam logic [7:0] WIDTH_C = 8'(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 128 || int'(NONE_CODE) < WIDTH) begin : g_bad_param
            $error("priority_code_decoder: WIDTH must be 2..128 and NONE_CODE >= WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             dup_q, dup_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [7:0]       top_q, top_d;
    logic [7:0]       pop_q, pop_d;
    logic             err_ill_q, err_ill_d;
    logic             err_dup_q, err_dup_d;

    // Summary of the accumulator as it stands this cycle.
    logic [WIDTH-1:0] acc_onehot;
    logic [7:0]       acc_top;
    logic [7:0]       acc_pop;

    logic             code_legal;
    logic [IDX_W-1:0] code_idx;

    assign code_legal = (bus.code_in < WIDTH_C);
    assign code_idx   = bus.code_in[IDX_W-1:0];

    // Highest set bit wins because later loop iterations overwrite earlier ones.
    always_comb begin
        acc_top    = NONE_CODE;
        acc_pop    = '0;
        acc_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (acc_q[i]) begin
                acc_top = 8'(i);
            end
            acc_pop = acc_pop + 8'(acc_q[i]);
        end
        if (acc_q != '0) begin
            acc_onehot[acc_top[IDX_W-1:0]] = 1'b1;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        dup_d     = dup_q;
        ill_d     = ill_q;
        mask_d    = mask_q;
        onehot_d  = onehot_q;
        top_d     = top_q;
        pop_d     = pop_q;
        err_ill_d = err_ill_q;
        err_dup_d = err_dup_q;

        unique case (state_q)
            COLLECT: begin
                if (bus.code_valid) begin
                    if (code_legal) begin
                        if (acc_q[code_idx]) begin
                            dup_d = 1'b1;
                        end
                        acc_d[code_idx] = 1'b1;
                    end else if (bus.code_in == NONE_CODE) begin
                        mask_d    = acc_q;
                        onehot_d  = acc_onehot;
                        top_d     = acc_top;
                        pop_d     = acc_pop;
                        err_ill_d = ill_q;
                        err_dup_d = dup_q;
                        state_d   = HOLD;
                    end else begin
                        ill_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Results stay put after release; only the frame state is cleared.
                if (bus.mask_ready) begin
                    acc_d   = '0;
                    dup_d   = 1'b0;
                    ill_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            acc_q     <= '0;
            dup_q     <= 1'b0;
            ill_q     <= 1'b0;
            mask_q    <= '0;
            onehot_q  <= '0;
            top_q     <= NONE_CODE;
            pop_q     <= '0;
            err_ill_q <= 1'b0;
            err_dup_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            dup_q     <= dup_d;
            ill_q     <= ill_d;
            mask_q    <= mask_d;
            onehot_q  <= onehot_d;
            top_q     <= top_d;
            pop_q     <= pop_d;
            err_ill_q <= err_ill_d;
            err_dup_q <= err_dup_d;
        end
    end

    assign bus.code_ready  = (state_q == COLLECT);
    assign bus.mask_valid  = (state_q == HOLD);
    assign bus.mask_out    = mask_q;
    assign bus.onehot_top  = onehot_q;
    assign bus.top_idx     = top_q;
    assign bus.pop_count   = pop_q;
    assign bus.err_illegal = err_ill_q;
    assign bus.err_dup     = err_dup_q;

endmodule

// File: doc/priority_code_decoder.md
Name: priority_code_decoder

Overview:
- Receive end of the priority-encoder code interface: consumes a stream of 8-bit index codes (0..WIDTH-1, or NONE_CODE for "no request") and rebuilds the WIDTH-bit request mask they describe.
- A frame is any number of index codes terminated by one NONE_CODE.
- On the terminator, the block publishes the rebuilt mask, a one-hot of its highest bit, the re-encoded top index, a population count and error flags, then holds them under a valid/ready handshake.
- Used for loopback checking of the encoder and for restoring request vectors on the far side of the 8-bit link.

Parameters:
- WIDTH, 16, mask width; legal range 2..128.
- NONE_CODE, 8'hF0, terminator/"no request" code; must be >= WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- code_in  in  8  index code
- code_valid  in  1  code_in valid
- code_ready  out  1  block accepts code_in this cycle
- mask_out  out  WIDTH  rebuilt request mask of last completed frame
- onehot_top  out  WIDTH  one-hot of highest set bit of mask_out, 0 if mask empty
- top_idx  out  8  index of highest set bit, NONE_CODE if mask empty (same coding as encoder output)
- pop_count  out  8  number of set bits in mask_out
- err_illegal  out  1  frame contained a code >= WIDTH other than NONE_CODE
- err_dup  out  1  frame contained the same legal index more than once
- mask_valid  out  1  result outputs valid
- mask_ready  in  1  consumer takes result

Behaviour:
- Reset, sampled at a clk edge with rst=1, takes effect at that edge and applies in any state, including mid-frame or while holding.
  - Reset values: state COLLECT; accumulator 0; mask_out 0; onehot_top 0; top_idx NONE_CODE; pop_count 0; err_illegal 0; err_dup 0; mask_valid 0.
  - code_ready is 1 in the first cycle after reset.
- FSM states:
  - COLLECT: code_ready=1, mask_valid=0.
  - HOLD: code_ready=0, mask_valid=1.
- In COLLECT, an accept (code_valid & code_ready) is handled by code value:
  - Code < WIDTH:
    - acc[code] <= 1.
    - If acc[code] was already 1, set the internal dup flag.
  - Code == NONE_CODE (terminator):
    - Load the output registers from the accumulator and flags as they stand this cycle: mask_out=acc; onehot_top=highest set bit of acc; top_idx=its index or NONE_CODE; pop_count=popcount(acc); err_illegal and err_dup from the internal flags.
    - Go to HOLD.
  - Any other code: accumulator unchanged; set the internal illegal flag.
- Latency: terminator accepted at edge N → mask_valid=1 and all result outputs valid after edge N (1 cycle).
- In HOLD:
  - All result outputs and mask_valid are stable until the handshake.
  - code_valid is ignored and nothing is consumed.
  - On mask_valid & mask_ready at edge M: go to COLLECT, and clear the accumulator and internal flags. mask_valid=0 and code_ready=1 after edge M.
  - Result outputs keep the last frame's values until the next terminator.
- Empty frame (terminator only): mask_out=0, onehot_top=0, top_idx=NONE_CODE, pop_count=0, flags 0.
- Results are consistent by construction: top_idx equals what the priority encoder produces for mask_out, and onehot_top == (1<<top_idx) when the mask is non-empty.
- mask_ready held high while in COLLECT has no effect.
- code_valid deasserted mid-frame pauses accumulation with no timeout; frame contents are preserved.
- pop_count maximum is WIDTH (≤128), so no saturation is needed.

Test Plan:
- Reset, then codes 3, 9, 0, F0 with code_valid held high and mask_ready=0 → one cycle after F0 accept: mask_valid=1, mask_out=16'h0209, top_idx=9, onehot_top=16'h0200, pop_count=3, both errors 0, code_ready=0. Outputs stay frozen for 5 cycles with codes still driven.
- Assert mask_ready for one cycle → mask_valid=0 and code_ready=1 next cycle. Then send F0 only → mask_out=0, top_idx=8'hF0, onehot_top=0, pop_count=0.
- Codes 15, 15, 22, F5, 2, F0 → mask_out=16'h8004, top_idx=15, pop_count=2, err_dup=1, err_illegal=1. The next frame (7, F0) reports both flags 0, top_idx=7.
- Codes 4, 11 with code_valid gaps of 3 idle cycles between each, then F0 → mask_out=16'h0810, top_idx=11. code_ready is high throughout COLLECT.
- Assert rst mid-frame after codes 1, 2, then send 5, F0 → mask_out=16'h0020 (earlier codes lost). rst asserted in HOLD → mask_valid=0, top_idx=8'hF0 next cycle.
- Loopback against tt_um_priority_encoder: random 16-bit vectors are sent as their set-bit index list plus F0 → mask_out equals the vector, and top_idx equals the encoder's uo_out for that vector, including 8'hF0 for all-zero.
